axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter sharing one AXI4-Stream sink (the stream consumer in top_axi4_stream) between N_SRC stream sources.
- Locks the grant on the first beat of a packet and holds it until the TLAST beat completes, so packets from different sources never interleave.
- Sits between the stream producers and the single consumer datapath.

Parameters:
- N_SRC, 2, number of requesting stream sources (1..8).
- DATA_W, 32, TDATA width in bits.
- ID_W, (N_SRC>1 ? $clog2(N_SRC) : 1), grant index width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- s_tvalid  in  N_SRC  per-source TVALID.
- s_tready  out  N_SRC  per-source TREADY.
- s_tdata  in  N_SRC*DATA_W  packed per-source TDATA; source i occupies bits [i*DATA_W +: DATA_W].
- s_tlast  in  N_SRC  per-source TLAST.
- m_tvalid  out  1  sink TVALID.
- m_tready  in  1  sink TREADY.
- m_tdata  out  DATA_W  sink TDATA.
- m_tlast  out  1  sink TLAST.
- grant_id  out  ID_W  index of the currently or most recently granted source.
- busy  out  1  high while a packet is locked.

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE, grant_id=0, busy=0, rr pointer last=N_SRC-1, so source 0 has top priority first.
- Reset combinational outputs:
  - m_tvalid=0, m_tlast=0, m_tdata=0.
  - s_tready=0 for all sources.
- Reset mid-packet abandons the lock immediately. No beat is transferred in the reset cycle.
- State IDLE:
  - All s_tready=0; m_tvalid=0; m_tdata=0; m_tlast=0.
  - If any s_tvalid is high, pick the first requester scanning last+1, last+2, … modulo N_SRC.
  - Register grant_id=winner, busy=1, and go to LOCK.
  - If no source is requesting, stay in IDLE.
- State LOCK, combinational pass-through of source g=grant_id:
  - m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g].
  - s_tready[g]=m_tready; every other s_tready=0.
- LOCK exit:
  - On a handshake (m_tvalid & m_tready) with m_tlast=1: last=g, busy=0, go to IDLE next cycle.
  - grant_id holds its value in IDLE.
- Latency:
  - Zero-cycle datapath within a packet; no registers on the data path.
  - One arbitration bubble cycle, spent in IDLE, between consecutive packets, including back-to-back packets from the same source.
- Fairness:
  - After source g finishes a packet, g has lowest priority at the next arbitration.
  - With N_SRC sources all continuously requesting, each source gets exactly one packet per N_SRC grants.
- Boundary conditions:
  - Single-beat packet (tlast on the first beat) locks and releases in one LOCK cycle.
  - If the granted source drops s_tvalid mid-packet, the lock is held and m_tvalid=0; other sources stay blocked.
  - A request arriving in the cycle the lock releases is eligible at the following IDLE cycle.
  - A source that deasserts s_tvalid during IDLE before being granted is simply not selected; no sticky requests.
  - N_SRC=1: grant is always 0, and the bubble cycle is still present.
  - m_tready low stalls the granted source; the lock is unaffected.

Optional Feature:
- Macro: AXIS_ARB_PKT_CNT_EN.
- Defined:
  - Adds output port pkt_cnt, width N_SRC*16; counter i occupies bits [i*16 +: 16].
  - Counter i increments by 1 on each TLAST handshake while grant_id==i.
  - Counters wrap 16'hFFFF→0 and reset to 0.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then rst=1 with no s_tvalid → m_tvalid=0, s_tready=0, busy=0, grant_id=0.
- Two-source contention:
  - Stimulus: src0 and src1 both present a 4-beat packet from the same cycle; src0 data 0x100..0x103, src1 data 0x200..0x203; m_tready=1.
  - Required: src0 packet first, one idle cycle, then src1 packet.
  - Required: m_tdata sequence 0x100,0x101,0x102,0x103,0x200,0x201,0x202,0x203; grant_id 0 then 1.
- Round-robin fairness: both sources continuously send 1-beat packets for 6 grants → grant_id alternates 0,1,0,1,0,1.
- Backpressure and gaps:
  - Stimulus: m_tready toggles every cycle; granted src1 drops s_tvalid for 3 cycles mid-packet while src0 requests.
  - Required: no beat lost or duplicated; s_tready[0]=0 throughout; busy=1 until src1's TLAST handshake.
- Reset mid-packet: assert rst=0 after beat 2 of 5 → next cycle busy=0, m_tvalid=0, grant_id=0; after release, src0 wins first arbitration.
- AXIS_ARB_PKT_CNT_EN: src0 sends 3 packets, src1 sends 2 packets → pkt_cnt[15:0]=3, pkt_cnt[31:16]=2; preload by sending 65536 packets on src0 → counter wraps to 0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: N_SRC AXI4-Stream sources share one sink, grant locked per packet.
// Optional per-source packet counters on output pkt_cnt when AXIS_ARB_PKT_CNT_EN is defined.
module axis_rr_arbiter #(
    parameter  int unsigned N_SRC  = 2,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          s_tvalid,
    output logic [N_SRC-1:0]          s_tready,
    input  logic [N_SRC*DATA_W-1:0]   s_tdata,
    input  logic [N_SRC-1:0]          s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tlast,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [N_SRC*16-1:0]       pkt_cnt
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q,  last_d;
    logic            busy_q,  busy_d;
    logic [ID_W-1:0] winner_c;
    logic            found_c;
    logic            release_c;

    // Round-robin scan starting just after the most recently served source.
    always_comb begin
        int unsigned idx;
        winner_c = '0;
        found_c  = 1'b0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = (32'(last_q) + k) % N_SRC;
            if (!found_c && s_tvalid[ID_W'(idx)]) begin
                found_c  = 1'b1;
                winner_c = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N_SRC - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    // Next state plus combinational pass-through; everything is gated off while in reset.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        busy_d    = busy_q;
        s_tready  = '0;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        release_c = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        grant_d = winner_c;
                        busy_d  = 1'b1;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    m_tvalid          = s_tvalid[grant_q];
                    m_tdata           = s_tdata[32'(grant_q)*DATA_W +: DATA_W];
                    m_tlast           = s_tlast[grant_q];
                    s_tready[grant_q] = m_tready;
                    release_c         = s_tvalid[grant_q] & m_tready & s_tlast[grant_q];
                    if (release_c) begin
                        last_d  = grant_q;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [N_SRC*CNT_W-1:0] cnt_q;

    // Per-source completed-packet counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (release_c) begin
            cnt_q[32'(grant_q)*CNT_W +: CNT_W] <= cnt_q[32'(grant_q)*CNT_W +: CNT_W] + 16'd1;
        end
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (N_SRC=2, DATA_W=32).
module tb_axis_rr_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0]   s_tdata;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]     m_tdata;
    logic [0:0]        grant_id;
    logic              busy;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [N*16-1:0]   pkt_cnt;
`endif

    axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .grant_id(grant_id), .busy(busy)
`ifdef AXIS_ARB_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned base[N], len[N], npkt[N], pos[N];
    bit          en[N], gap[N], hs[N];
    bit          tog;
    int          n_run, n_fail, cyc;
    logic [31:0] beats[$];
    int          stamps[$];
    int          grants[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < int'(N); i++) begin
            bit act;
            act = en[i] && (pos[i] < len[i] * npkt[i]) && !gap[i];
            s_tvalid[i]        = act;
            s_tdata[i*DW +: DW] = act ? 32'(base[i] + pos[i]) : 32'h0;
            s_tlast[i]         = act && ((pos[i] % len[i]) == len[i] - 1);
        end
    endtask

    // One clock: record the sink side before the edge, advance sources after it.
    task automatic tick();
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            beats.push_back(m_tdata);
            stamps.push_back(cyc);
            if (m_tlast) grants.push_back(int'(grant_id));
        end
        for (int i = 0; i < int'(N); i++) hs[i] = s_tvalid[i] && s_tready[i];
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < int'(N); i++) if (hs[i]) pos[i]++;
        if (tog) m_tready = ~m_tready;
        drive();
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < int'(N); i++) if (en[i] && pos[i] < len[i] * npkt[i]) p = 1'b1;
        return p;
    endfunction

    task automatic setup(input int i, input int unsigned b, input int unsigned l, input int unsigned n);
        base[i] = b; len[i] = l; npkt[i] = n; pos[i] = 0; en[i] = 1'b1; gap[i] = 1'b0;
    endtask

    task automatic clear();
        beats.delete(); stamps.delete(); grants.delete();
        for (int i = 0; i < int'(N); i++) begin
            en[i] = 1'b0; gap[i] = 1'b0; pos[i] = 0; len[i] = 1; npkt[i] = 0; base[i] = 0;
        end
    endtask

    task automatic run_done(input string tag, input int maxc);
        int c = 0;
        while (pending() && c < maxc) begin
            tick();
            c++;
        end
        check(tag, 32'(pending()), 32'd0);
    endtask

    initial begin
        logic [31:0] exp2 [8];
        logic [31:0] exp3 [6];
        logic [31:0] exp4 [5];
        int          v, gapn, c;

        n_run = 0; n_fail = 0; cyc = 0; tog = 1'b0;
        exp2 = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200, 32'h201, 32'h202, 32'h203};
        exp3 = '{32'h300, 32'h400, 32'h301, 32'h401, 32'h302, 32'h402};
        exp4 = '{32'h500, 32'h501, 32'h502, 32'h503, 32'h600};

        // Reset: a requesting source must see no ready while rst is low.
        clear();
        rst = 1'b0; m_tready = 1'b1;
        setup(0, 32'h50, 2, 1);
        drive();
        repeat (2) @(posedge clk);
        #2;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        en[0] = 1'b0; drive();
        rst = 1'b1;
        tick(); tick();
        check("idle_m_tvalid", 32'(m_tvalid), 32'd0);
        check("idle_s_tready", 32'(s_tready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_grant", 32'(grant_id), 32'd0);

        // Two-source contention, 4-beat packets.
        clear();
        setup(0, 32'h100, 4, 1);
        setup(1, 32'h200, 4, 1);
        drive();
        run_done("cont_done", 40);
        check("cont_nbeats", 32'(beats.size()), 32'd8);
        if (beats.size() == 8)
            for (int k = 0; k < 8; k++) check($sformatf("cont_beat%0d", k), beats[k], exp2[k]);
        check("cont_ngrants", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            check("cont_grant0", 32'(grants[0]), 32'd0);
            check("cont_grant1", 32'(grants[1]), 32'd1);
        end
        if (stamps.size() == 8) begin
            check("cont_pkt_span", 32'(stamps[3] - stamps[0]), 32'd3);
            check("cont_bubble", 32'(stamps[4] - stamps[3]), 32'd2);
        end

        // Fairness: single-beat packets from both sources.
        clear();
        setup(0, 32'h300, 1, 3);
        setup(1, 32'h400, 1, 3);
        drive();
        run_done("rr_done", 60);
        check("rr_nbeats", 32'(beats.size()), 32'd6);
        if (beats.size() == 6)
            for (int k = 0; k < 6; k++) begin
                check($sformatf("rr_beat%0d", k), beats[k], exp3[k]);
                check($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(k % 2));
            end

        // Backpressure and a 3-cycle gap from the granted source while src0 waits.
        clear();
        setup(1, 32'h500, 4, 1);
        drive();
        c = 0;
        while (!(busy && grant_id == 1'b1) && c < 10) begin
            tick();
            c++;
        end
        check("bp_locked", 32'(busy && grant_id == 1'b1), 32'd1);
        setup(0, 32'h600, 1, 1);
        tog = 1'b1;
        v = 0; gapn = 0; c = 0;
        while (pending() && c < 60) begin
            if (pos[1] == 2 && gapn < 3) begin
                gap[1] = 1'b1;
                gapn++;
            end else begin
                gap[1] = 1'b0;
            end
            drive();
            #1;
            if (pos[1] < 4) begin
                if (s_tready[0]) v++;
                if (!busy) v++;
                if (gap[1] && m_tvalid) v++;
            end
            tick();
            c++;
        end
        tog = 1'b0; m_tready = 1'b1;
        check("bp_done", 32'(pending()), 32'd0);
        check("bp_violations", 32'(v), 32'd0);
        check("bp_gap_cycles", 32'(gapn), 32'd3);
        check("bp_nbeats", 32'(beats.size()), 32'd5);
        if (beats.size() == 5)
            for (int k = 0; k < 5; k++) check($sformatf("bp_beat%0d", k), beats[k], exp4[k]);
        if (grants.size() == 2) begin
            check("bp_grant0", 32'(grants[0]), 32'd1);
            check("bp_grant1", 32'(grants[1]), 32'd0);
        end

        // Reset in the middle of a 5-beat packet from src1.
        clear();
        setup(1, 32'h700, 5, 1);
        setup(0, 32'h800, 1, 1);
        drive();
        c = 0;
        while (pos[1] < 2 && c < 20) begin
            tick();
            c++;
        end
        check("mid_grant_pre", 32'(grant_id), 32'd1);
        rst = 1'b0;
        #2;
        check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_s_tready", 32'(s_tready), 32'd0);
        tick();
        en[1] = 1'b0;
        rst = 1'b1;
        drive();
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_grant", 32'(grant_id), 32'd0);
        check("mid_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_src1_pos", 32'(pos[1]), 32'd2);
        tick();
        #1;
        check("mid_rearb_grant", 32'(grant_id), 32'd0);
        check("mid_rearb_busy", 32'(busy), 32'd1);
        check("mid_rearb_data", m_tdata, 32'h800);
        run_done("mid_done", 10);

`ifdef AXIS_ARB_PKT_CNT_EN
        // Packet counters from a fresh reset.
        clear();
        drive();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        setup(0, 32'h900, 2, 3);
        setup(1, 32'hA00, 2, 2);
        drive();
        run_done("cnt_done", 100);
        tick();
        check("cnt_src0", 32'(pkt_cnt[15:0]), 32'd3);
        check("cnt_src1", 32'(pkt_cnt[31:16]), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
